// File: rtl/reg_share_arbiter_pkg.sv
// reg_share_arbiter_pkg: shared types and helpers for the register-sharing arbiter.
//   state_t  holding-register occupancy (ST_EMPTY / ST_FULL)
//   src_w()  width of a requester index, never narrower than one bit
package reg_share_arbiter_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic int src_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin requester selection with an owned priority pointer.
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        request vector, bit i = requester i
//   i_advance    a grant was accepted this cycle; move the pointer past the winner
//   o_grant      one-hot grant (zero when no request)
//   o_grant_idx  index of the granted requester
//   o_any_req    at least one request is present
module rr_arbiter
   import reg_share_arbiter_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int SRC_W = src_w(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_advance,
   output logic [N_REQ-1:0] o_grant,
   output logic [SRC_W-1:0] o_grant_idx,
   output logic             o_any_req
);

   logic [SRC_W-1:0] ptr;
   int               cand;

   // Scan from the farthest offset back to ptr so the closest requester at or
   // after ptr is the last one written and therefore wins.
   always_comb begin
      o_grant_idx = '0;
      o_any_req   = 1'b0;
      cand        = 0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         cand = int'(ptr) + j;
         cand = (cand >= N_REQ) ? cand - N_REQ : cand;
         if (i_req[cand]) begin
            o_grant_idx = cand[SRC_W-1:0];
            o_any_req   = 1'b1;
         end
      end
   end

   always_comb begin
      o_grant              = '0;
      o_grant[o_grant_idx] = o_any_req;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         ptr <= '0;
      else if (i_advance && o_any_req)
         ptr <= (int'(o_grant_idx) == N_REQ - 1) ? '0 : o_grant_idx + 1'b1;
   end

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: N_REQ producers time-share one WIDTH-bit holding register.
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester valid
//   i_req_data   requester i data at [i*WIDTH +: WIDTH]
//   o_req_ready  one-hot-or-zero grant; transfer when valid & ready
//   o_q          held value
//   o_q_valid    o_q holds an unconsumed value
//   o_q_src      requester that supplied o_q
//   i_q_ack      consumer takes o_q this cycle (ignored while empty)
module reg_share_arbiter
   import reg_share_arbiter_pkg::*;
#(
   parameter  int WIDTH = 10,
   parameter  int N_REQ = 4,
   localparam int SRC_W = src_w(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ*WIDTH-1:0] i_req_data,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic [WIDTH-1:0]       o_q,
   output logic                   o_q_valid,
   output logic [SRC_W-1:0]       o_q_src,
   input  logic                   i_q_ack
);

   state_t           state;
   logic             load_en;
   logic             any_req;
   logic             xfer;
   logic [N_REQ-1:0] grant;
   logic [SRC_W-1:0] win;

   // The register can accept new data when empty, or when its current value is
   // being consumed this very cycle (consume and reload without a bubble).
   assign load_en     = (state == ST_EMPTY) || i_q_ack;
   assign xfer        = load_en && any_req;
   assign o_req_ready = (i_rst_n && load_en) ? grant : '0;
   assign o_q_valid   = (state == ST_FULL);

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       (i_req_valid),
      .i_advance   (xfer),
      .o_grant     (grant),
      .o_grant_idx (win),
      .o_any_req   (any_req)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_EMPTY;
         o_q     <= '0;
         o_q_src <= '0;
      end else if (load_en) begin
         state <= any_req ? ST_FULL : ST_EMPTY;
         if (any_req) begin
            o_q     <= i_req_data[int'(win)*WIDTH +: WIDTH];
            o_q_src <= win;
         end
      end
   end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: vector table, directed reset sequence and randomized model check.
module tb_reg_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [39:0] req_data;
   logic [3:0]  req_ready;
   logic [9:0]  q;
   logic        q_valid;
   logic [1:0]  q_src;
   logic        q_ack;

   int tests = 0;
   int fails = 0;

   bit       m_full;
   bit [9:0] m_q;
   int       m_src;
   int       m_ptr;

   typedef struct {
      logic [3:0]  v;
      logic [39:0] d;
      logic        a;
      logic [3:0]  rdy;
      logic [9:0]  q;
      logic        qv;
      logic [1:0]  src;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   reg_share_arbiter #(.WIDTH(10), .N_REQ(4)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .o_q         (q),
      .o_q_valid   (q_valid),
      .o_q_src     (q_src),
      .i_q_ack     (q_ack)
   );

   function automatic logic [39:0] pk(input logic [9:0] d3, d2, d1, d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic add(input logic [3:0] v, input logic [39:0] d, input logic a,
                      input logic [3:0] rdy, input logic [9:0] eq, input logic qv,
                      input logic [1:0] src);
      vec_t r;
      r.v = v; r.d = d; r.a = a; r.rdy = rdy; r.q = eq; r.qv = qv; r.src = src;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 0; m_q = '0; m_src = 0; m_ptr = 0;
   endtask

   // Reference behaviour: if the register can take data, the first valid
   // requester at or after the pointer (modulo 4) wins.
   task automatic model_step(input logic [3:0] v, input logic [39:0] d, input logic a,
                             output logic [3:0] rdy);
      int w;
      w   = -1;
      rdy = '0;
      if (!m_full || a) begin
         for (int j = 0; j < 4; j++)
            if (w < 0 && v[(m_ptr + j) % 4]) w = (m_ptr + j) % 4;
         if (w >= 0) begin
            rdy[w] = 1'b1;
            m_q    = d[w*10 +: 10];
            m_src  = w;
            m_full = 1;
            m_ptr  = (w + 1) % 4;
         end else begin
            m_full = 0;
         end
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [39:0] d, input logic a,
                        output logic [3:0] rdy);
      req_valid = v;
      req_data  = d;
      q_ack     = a;
      #1;
      rdy = req_ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  rdy;
      logic [3:0]  er;
      logic [3:0]  v;
      logic [39:0] d;
      logic [63:0] r64;
      logic        a;

      add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b1, 4'b0001, 10'h001, 1'b1, 2'd0);
      add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b1, 4'b0010, 10'h002, 1'b1, 2'd1);
      add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b1, 4'b0100, 10'h003, 1'b1, 2'd2);
      add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b1, 4'b1000, 10'h004, 1'b1, 2'd3);
      add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b1, 4'b0001, 10'h001, 1'b1, 2'd0);
      add(4'b0100, pk(10'h000, 10'h155, 10'h000, 10'h000), 1'b1, 4'b0100, 10'h155, 1'b1, 2'd2);
      add(4'b0000, 40'h0,                                   1'b1, 4'b0000, 10'h155, 1'b0, 2'd2);
      add(4'b0000, 40'h0,                                   1'b1, 4'b0000, 10'h155, 1'b0, 2'd2);
      add(4'b1001, pk(10'h0B0, 10'h000, 10'h000, 10'h00A), 1'b0, 4'b1000, 10'h0B0, 1'b1, 2'd3);
      add(4'b1001, pk(10'h0B0, 10'h000, 10'h000, 10'h00A), 1'b1, 4'b0001, 10'h00A, 1'b1, 2'd0);
      add(4'b1001, pk(10'h0B0, 10'h000, 10'h000, 10'h00A), 1'b1, 4'b1000, 10'h0B0, 1'b1, 2'd3);
      add(4'b0010, pk(10'h000, 10'h000, 10'h0AA, 10'h000), 1'b1, 4'b0010, 10'h0AA, 1'b1, 2'd1);
      for (int i = 0; i < 5; i++)
         add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b0, 4'b0000, 10'h0AA, 1'b1, 2'd1);
      add(4'b1111, pk(10'h004, 10'h003, 10'h002, 10'h001), 1'b1, 4'b0100, 10'h003, 1'b1, 2'd2);

      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = pk(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
      q_ack     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q", 32'(q), 32'h0);
      chk("reset_q_valid", 32'(q_valid), 32'h0);
      chk("reset_q_src", 32'(q_src), 32'h0);
      chk("reset_ready", 32'(req_ready), 32'h0);
      rst_n = 1'b1;
      model_reset();

      foreach (tbl[i]) begin
         model_step(tbl[i].v, tbl[i].d, tbl[i].a, er);
         drive(tbl[i].v, tbl[i].d, tbl[i].a, rdy);
         chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
         chk($sformatf("vec%0d_q_valid", i), 32'(q_valid), 32'(tbl[i].qv));
         chk($sformatf("vec%0d_q_src", i), 32'(q_src), 32'(tbl[i].src));
      end

      model_step(4'b0001, pk(10'h0, 10'h0, 10'h0, 10'h3FF), 1'b1, er);
      drive(4'b0001, pk(10'h0, 10'h0, 10'h0, 10'h3FF), 1'b1, rdy);
      chk("midrst_pre_ready", 32'(rdy), 32'b0001);
      chk("midrst_pre_q", 32'(q), 32'h3FF);
      chk("midrst_pre_q_valid", 32'(q_valid), 32'h1);
      req_valid = 4'b1111;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_q", 32'(q), 32'h0);
      chk("midrst_q_valid", 32'(q_valid), 32'h0);
      chk("midrst_q_src", 32'(q_src), 32'h0);
      chk("midrst_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      model_step(4'b0110, pk(10'h0, 10'h111, 10'h222, 10'h0), 1'b1, er);
      drive(4'b0110, pk(10'h0, 10'h111, 10'h222, 10'h0), 1'b1, rdy);
      chk("postrst_ready", 32'(rdy), 32'b0010);
      chk("postrst_q", 32'(q), 32'h222);
      chk("postrst_q_src", 32'(q_src), 32'h1);
      chk("postrst_q_valid", 32'(q_valid), 32'h1);

      for (int i = 0; i < 400; i++) begin
         v   = 4'($urandom_range(0, 15));
         r64 = {$urandom(), $urandom()};
         d   = r64[39:0];
         a   = ($urandom_range(0, 3) != 0);
         model_step(v, d, a, er);
         drive(v, d, a, rdy);
         chk($sformatf("rand%0d_ready", i), 32'(rdy), 32'(er));
         chk($sformatf("rand%0d_q", i), 32'(q), 32'(m_q));
         chk($sformatf("rand%0d_q_valid", i), 32'(q_valid), 32'(m_full));
         chk($sformatf("rand%0d_q_src", i), 32'(q_src), 32'(m_src));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one WIDTH-bit holding register among N_REQ requesters. Each requester presents data with a valid/ready handshake. The winner's data is loaded into the register and presented downstream until the consumer acknowledges it. The block sits in front of the plain parameterized data register in the datapath and replaces it wherever several producers must time-share one registered output.

## Interface
- WIDTH, 10, data width of each requester and of the held value
- N_REQ, 4, number of requesters (≥1); SRC_W = max(1, clog2(N_REQ))
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset; asynchronous assert, active-low
- i_req_valid  input  N_REQ  bit i: requester i has data
- i_req_data  input  N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- o_req_ready  output  N_REQ  one-hot-or-zero grant; transfer when valid[i] & ready[i]
- o_q  output  WIDTH  held value
- o_q_valid  output  1  o_q holds an unconsumed value
- o_q_src  output  SRC_W  index of the requester that supplied o_q
- i_q_ack  input  1  consumer takes o_q this cycle (meaningful only when o_q_valid)

## Operation
- Two states: EMPTY (o_q_valid=0) and FULL (o_q_valid=1).
- load_en = EMPTY | (FULL & i_q_ack).
- Arbitration: round-robin pointer ptr (SRC_W bits). The winner is the first requester with valid=1, searching ptr, ptr+1, … mod N_REQ.
- o_req_ready[winner]=1 only when load_en and at least one valid is set. All other ready bits are 0. Ready is combinational from valid, state and ack.
- On a transfer to winner k:
  - o_q ← data[k], o_q_src ← k, state → FULL.
  - ptr ← (k+1) mod N_REQ. Wrap: k = N_REQ-1 gives ptr 0.
- FULL & i_q_ack & no valid → EMPTY. o_q and o_q_src keep their last value.
- FULL & !i_q_ack → hold everything; all ready bits 0.
- EMPTY & no valid → stay EMPTY; ptr unchanged.
- ptr changes only on a transfer.
- i_q_ack while EMPTY is ignored.
- Non-winning requesters must hold valid/data; the block keeps no per-requester state.
- Reset values: o_q=0, o_q_valid=0, o_q_src=0, ptr=0, state EMPTY.
- While i_rst_n=0, o_req_ready is forced to 0.
- Reset mid-operation: any held value is discarded immediately; there is no pending-transfer recovery.

## Timing
- Request-to-output latency: 1 cycle. A transfer at edge t gives o_q/o_q_valid updated after edge t.
- Throughput: 1 transfer per cycle when i_q_ack=1 each cycle FULL.
- Consume and reload happen in the same cycle: ack plus a new transfer give no bubble, and o_q_valid stays 1.
- Fairness: a continuously valid requester is granted within N_REQ transfers.
- No combinational path from i_req_data to o_q.
- Combinational paths exist i_req_valid→o_req_ready and i_q_ack→o_req_ready; upstream must not make valid depend on ready.

## Structure
- Shared package holds:
  - state enum {ST_EMPTY, ST_FULL};
  - function src_w(n) returning max(1, clog2(n)).
- Sub-module rr_arbiter:
  - parameter N_REQ;
  - inputs i_clk, i_rst_n, req vector, advance strobe;
  - outputs one-hot grant, grant index, any_req;
  - owns ptr.
- Top holds the FSM, holding register and data mux.

## Test plan
- Reset: assert i_rst_n=0 with all valid=1 → o_q=0, o_q_valid=0, o_q_src=0, o_req_ready=0000.
- Single source: N_REQ=4, only valid[2]=1 with data 0x155, ack=1 → ready=0100 for one cycle; next cycle o_q=0x155, o_q_valid=1, o_q_src=2.
- Round-robin: all four valid continuously, distinct data 0x001..0x004, ack=1 → o_q_src 0,1,2,3,0 on consecutive cycles; o_q_valid stays 1.
- Backpressure: FULL with o_q=0x0AA, ack=0 for 5 cycles, all valid → o_q stable, ready=0000. Then ack=1 → next winner ready the same cycle and o_q updates on the next cycle with no bubble.
- Wrap: last grant to 3, then valid[0] and valid[3] both set → requester 0 wins, ptr=1.
- Reset mid-operation: drop i_rst_n while FULL with o_q=0x3FF → o_q_valid=0 and o_q=0 before the next clock edge. After release, the first grant goes to the lowest valid index.
